// File: rtl/sapho_io_responder.sv
// Generic circular FIFO with binary pointers (one extra wrap bit) and registered storage.
// Latency: a word written at edge t is at the head from cycle t+1; head is combinational from storage.
// Backpressure: a push is taken when not full, or when full and a pop happens on the same edge.
module sapho_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               head_dat,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         full;
    logic         wr_en;
    logic         rd_en;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        level    = wr_ptr_q - rd_ptr_q;
        head_dat = mem_q[rd_ptr_q[AW-1:0]];
        rd_en    = pop && !empty;
        wr_en    = push_vld && (!full || rd_en);
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: contents are only observed through the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
        end
    end
endmodule

// SAPHO I/O bus responder: streams words into the processor input port and captures its output writes.
// Latency: stream word visible on proc_io_in one cycle after acceptance; captured write on m_* one cycle later.
// Backpressure: s_ready drops when the input FIFO is full; output writes to a full FIFO are dropped and flagged.
module sapho_io_responder #(
    parameter int DATA_W    = 32,
    parameter int NUM_IN    = 2,
    parameter int NUM_OUT   = 5,
    parameter int IN_PORT   = 1,
    parameter int IN_DEPTH  = 16,
    parameter int OUT_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [DATA_W-1:0]             proc_io_in,
    input  logic [NUM_IN-1:0]             proc_req_in,
    input  logic [DATA_W-1:0]             proc_io_out,
    input  logic [NUM_OUT-1:0]            proc_out_en,
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [DATA_W-1:0]             m_data,
    output logic [$clog2(NUM_OUT)-1:0]    m_port,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(IN_DEPTH):0]     in_level,
    input  logic                          clr_status,
    output logic                          underflow,
    output logic                          overflow,
    output logic                          proto_err
);
    localparam int PORT_W    = $clog2(NUM_OUT);
    localparam int IN_LVL_W  = $clog2(IN_DEPTH) + 1;
    localparam int OUT_LVL_W = $clog2(OUT_DEPTH) + 1;
    localparam int OUT_W     = PORT_W + DATA_W;

    logic                 req;
    logic                 in_push;
    logic                 in_pop;
    logic                 in_empty;
    logic [DATA_W-1:0]    in_head;

    logic                 out_one_hot;
    logic                 out_multi;
    logic                 out_full;
    logic                 out_push;
    logic                 out_pop;
    logic                 out_empty;
    logic [PORT_W-1:0]    wr_port;
    logic [OUT_W-1:0]     out_head;
    logic [OUT_LVL_W-1:0] out_level;

    logic                 underflow_q, underflow_d;
    logic                 overflow_q, overflow_d;
    logic                 proto_err_q, proto_err_d;
    logic                 unused_req;

    // Only one request bit belongs to this block; the rest address other responders.
    assign unused_req = ^proc_req_in;

    // Input side.
    always_comb begin
        req        = proc_req_in[IN_PORT];
        s_ready    = (in_level != IN_LVL_W'(IN_DEPTH));
        in_push    = s_valid && s_ready;
        in_pop     = req && !in_empty;
        proc_io_in = in_pop ? in_head : '0;
    end

    sapho_fifo #(
        .W     (DATA_W),
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (in_push),
        .push_dat (s_data),
        .pop      (in_pop),
        .head_dat (in_head),
        .empty    (in_empty),
        .level    (in_level)
    );

    // Output side: decode the one-hot enable into a port index.
    always_comb begin
        out_one_hot = (|proc_out_en) && !(|(proc_out_en & (proc_out_en - NUM_OUT'(1))));
        out_multi   = (|proc_out_en) && !out_one_hot;
        wr_port     = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (proc_out_en[i]) begin
                wr_port = PORT_W'(i);
            end
        end
    end

    always_comb begin
        m_valid  = !out_empty;
        out_pop  = m_valid && m_ready;
        out_full = (out_level == OUT_LVL_W'(OUT_DEPTH));
        out_push = out_one_hot && (!out_full || out_pop);
        m_data   = m_valid ? out_head[DATA_W-1:0] : '0;
        m_port   = m_valid ? out_head[OUT_W-1:DATA_W] : '0;
    end

    sapho_fifo #(
        .W     (OUT_W),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (out_push),
        .push_dat ({wr_port, proc_io_out}),
        .pop      (out_pop),
        .head_dat (out_head),
        .empty    (out_empty),
        .level    (out_level)
    );

    // Sticky flags: a fresh event on the clearing edge keeps the flag set.
    always_comb begin
        underflow_d = (underflow_q && !clr_status) || (req && in_empty);
        overflow_d  = (overflow_q && !clr_status) || (out_one_hot && !out_push);
        proto_err_d = (proto_err_q && !clr_status) || out_multi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign underflow = underflow_q;
    assign overflow  = overflow_q;
    assign proto_err = proto_err_q;
endmodule

// File: doc/sapho_io_responder.md
Name: sapho_io_responder

Overview:
- Synthesizable peripheral on the far side of the SAPHO processor I/O bus. Replaces the simulation-only stimulus/capture environment with hardware.
- Input side: buffers words arriving on a valid/ready stream. Serves one word each time the processor asserts its input-request bit for this port.
- Output side: captures every processor output write together with its port index into a FIFO, drained through a valid/ready stream.
- Sits between the processor instance (io_in/io_out/req_in/out_en) and the surrounding datapath or host interface.

Parameters:
- DATA_W, 32, width of processor I/O words (signed, two's complement).
- NUM_IN, 2, width of proc_req_in (one bit per input port).
- NUM_OUT, 5, width of proc_out_en (one bit per output port).
- IN_PORT, 1, bit index of proc_req_in served by this block.
- IN_DEPTH, 16, input FIFO depth (power of 2, >= 2).
- OUT_DEPTH, 16, output FIFO depth (power of 2, >= 2).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- proc_io_in  out  DATA_W  data to processor.
- proc_req_in  in  NUM_IN  processor input-request bitmap.
- proc_io_out  in  DATA_W  data from processor.
- proc_out_en  in  NUM_OUT  processor output-enable bitmap (one-hot).
- s_data  in  DATA_W  input stream data.
- s_valid  in  1  input stream valid.
- s_ready  out  1  input stream ready; equals !in_full.
- m_data  out  DATA_W  captured output word.
- m_port  out  $clog2(NUM_OUT)  port index of m_data.
- m_valid  out  1  output stream valid.
- m_ready  in  1  output stream ready.
- in_level  out  $clog2(IN_DEPTH)+1  input FIFO occupancy.
- clr_status  in  1  clears sticky flags.
- underflow  out  1  sticky: request served while input FIFO was empty.
- overflow  out  1  sticky: output write dropped because output FIFO was full.
- proto_err  out  1  sticky: proc_out_en had more than one bit set.

Behaviour:
- Reset (rst=1 at a rising edge):
  - Both FIFOs emptied; in_level=0.
  - s_ready=1, m_valid=0, m_data=0, m_port=0, proc_io_in=0.
  - All sticky flags 0.
  - Reset mid-transfer discards all buffered words.
- Input push: s_valid && s_ready at an edge writes s_data.
- Input presentation and pop:
  - proc_io_in equals the FIFO head (combinational from registered storage) while proc_req_in[IN_PORT]=1 and FIFO non-empty; otherwise 0.
  - Head pops at each rising edge where proc_req_in[IN_PORT]=1 and FIFO non-empty.
  - A request held N cycles pops N words.
- Input latency: a word pushed at edge t is visible on proc_io_in from cycle t+1. No same-cycle bypass into an empty FIFO.
- Input underflow: request while empty gives proc_io_in=0, no pop, underflow set. A simultaneous push is still accepted.
- Simultaneous input push+pop: allowed at any level including full (s_ready is low at full, so only pop occurs); in_level unchanged when both occur.
- Other proc_req_in bits are ignored.
- Output capture:
  - At a rising edge where proc_out_en has exactly one bit k set, {k, proc_io_out} is pushed.
  - m_valid rises the next cycle if the FIFO was empty (one-cycle latency).
  - proc_out_en=0 means no action.
  - Two or more bits set: no push, proto_err set.
- Output full:
  - A push is dropped and overflow set, unless m_valid && m_ready in the same cycle, in which case pop and push both occur and nothing is dropped.
- Output drain: m_data/m_port hold stable while m_valid && !m_ready. Pop on m_valid && m_ready.
- Pointer wrap: binary pointers with one extra bit; full/empty from MSB compare. Wrap is seamless.
- clr_status=1 clears all sticky flags at the edge. A new error event in the same cycle wins (flag stays set).
- Data treated as opaque bits; signedness preserved bit-exactly.

Test Plan:
- Push 5, -3, 7 (s_valid 3 cycles), then assert proc_req_in=2'b10 for 3 cycles -> proc_io_in reads 5, -3, 7 in order; in_level 3->0; underflow stays 0.
- Empty FIFO, proc_req_in=2'b10 one cycle -> proc_io_in=0, underflow=1. Then clr_status -> underflow=0. Then proc_req_in=2'b01 -> no pop, no flag.
- Fill input to 16 -> s_ready=0, in_level=16. Then req+push same cycle -> only pop, level 15. Next cycle push+req -> level stays 15.
- m_ready=1, proc_out_en=5'b00100 with io_out=-42 -> next cycle m_valid=1, m_port=2, m_data=-42. Then out_en=5'b10000 with 99 -> m_port=4, m_data=99.
- m_ready=0, 17 consecutive one-hot writes -> 16 stored, overflow=1. Then 17th write with m_ready=1 at full -> accepted, no drop; drained order matches write order.
- proc_out_en=5'b00011 -> nothing pushed, proto_err=1. Then rst asserted mid-stream -> all outputs at reset values on the next cycle.
